mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester of the multicycle CPU.
- Arbitrates between the two requesters, latches the winning request, and drives the memory for a fixed number of wait-state cycles.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the control unit/datapath and the memory array; replaces ad-hoc IorD steering.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- MEM_LATENCY, 2, memory access cycles per transfer (legal range 1..15)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- IReq  input  1  fetch request; held until IAck
- IAddr  input  ADDRESS_WIDTH  fetch address
- IAck  output  1  one-cycle pulse: fetch complete, IData valid
- IData  output  DATA_WIDTH  fetched word; holds until next fetch completes
- DReq  input  1  data request; held until DAck
- DWrite  input  1  1 = store, 0 = load; sampled with DReq
- DAddr  input  ADDRESS_WIDTH  data address
- DWData  input  DATA_WIDTH  store data
- DAck  output  1  one-cycle pulse: data access complete
- DRData  output  DATA_WIDTH  load result; holds until next load completes
- MemAddress  output  ADDRESS_WIDTH  latched address to memory
- MemWriteData  output  DATA_WIDTH  latched store data
- MemEnable  output  1  high for every ACCESS cycle
- MemWrite  output  1  write strobe to memory
- MemReadData  input  DATA_WIDTH  memory read port
- Busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE, all outputs 0, LastGrant = I (so the first contention goes to D). Reset mid-access aborts the access: MemWrite drops immediately, no ack is issued, and no partial write completes.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one request is active, grant it.
  - If both are active, grant the requester opposite LastGrant (round-robin), then update LastGrant.
  - On grant, latch address, write flag and store data into registers (I grant forces write = 0), load counter = MEM_LATENCY-1, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - MemEnable = 1; MemAddress and MemWriteData come from the latched registers and are stable for the whole access.
  - MemWrite = 1 only in the final ACCESS cycle (counter = 0) of a store, giving exactly one write strobe per store.
  - Counter decrements each cycle. When the counter is 0: for a load or fetch, capture MemReadData into DRData or IData; then go to DONE.
- DONE:
  - Assert IAck or DAck for the granted requester for exactly 1 cycle, then return to IDLE.
  - DAck is asserted for stores too; DRData is not updated by a store.
- Latency: request seen in IDLE at cycle 0 → ack asserted in cycle MEM_LATENCY+1. Minimum back-to-back period is MEM_LATENCY+2 cycles.
- Handshake rules:
  - The requester holds Req and its operands stable until ack. Changes to operands after the grant cycle are ignored.
  - The requester must drop Req in the cycle after ack; a Req still high in the following IDLE cycle is a new request.
  - Req sampled in ACCESS or DONE is ignored.
  - Req dropped mid-access does not abort: the access completes and the ack is still pulsed.
- IAck and DAck are never high in the same cycle. MemWrite is never high outside ACCESS.
- IData and DRData are registered; they change only in the final ACCESS cycle of a matching read.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, ACCESS, DONE)
  - grant encoding (GRANT_I = 0, GRANT_D = 1)
  - default MEM_LATENCY
- One sub-module, wait_counter: loadable down-counter with a zero flag, width 4, reused later by the cache/IO controllers.
- FSM, arbitration and latches stay in the top module.

Test Plan:
- Single fetch, MEM_LATENCY = 2: IReq with IAddr = 0x00000010, memory returns 0x8C020004 → MemEnable high for cycles 1–2, IAck pulse in cycle 3, IData = 0x8C020004, Busy low in cycle 4.
- Store: DReq, DWrite = 1, DAddr = 0x100, DWData = 0xDEADBEEF → exactly one MemWrite cycle (cycle 2) with MemAddress = 0x100 and MemWriteData = 0xDEADBEEF; DAck in cycle 3; DRData unchanged.
- Contention: IReq and DReq both high from reset, both held after each ack → grant order D, I, D; acks in cycles 3, 7, 11; never simultaneous.
- Req dropped mid-access: load at 0x200, DReq deasserted in cycle 1 → access still completes, DAck in cycle 3, DRData = memory word at 0x200.
- Reset mid-store: assert Reset in cycle 1 of a store with MEM_LATENCY = 3 → MemWrite never asserted, DAck = 0, state IDLE, Busy = 0.
- MEM_LATENCY = 1: back-to-back loads → ack every 3 cycles; counter zero-flag boundary handled correctly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter and its helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } grant_e;

  localparam int unsigned DefaultMemLatency = 2;
  localparam int unsigned CountWidth        = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and
// load/store; latches the winning request and drives a fixed-length access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_LATENCY   = DefaultMemLatency
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     IReq,
  input  logic [ADDRESS_WIDTH-1:0] IAddr,
  output logic                     IAck,
  output logic [DATA_WIDTH-1:0]    IData,
  input  logic                     DReq,
  input  logic                     DWrite,
  input  logic [ADDRESS_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0]    DWData,
  output logic                     DAck,
  output logic [DATA_WIDTH-1:0]    DRData,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  output logic                     MemEnable,
  output logic                     MemWrite,
  input  logic [DATA_WIDTH-1:0]    MemReadData,
  output logic                     Busy
);

  localparam logic [CountWidth-1:0] LoadVal = CountWidth'(MEM_LATENCY - 1);

  arb_state_e               state_q, state_d;
  grant_e                   grant_q, grant_d;
  grant_e                   last_grant_q, last_grant_d;
  grant_e                   pick;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    idata_q, idata_d;
  logic [DATA_WIDTH-1:0]    drdata_q, drdata_d;
  logic                     write_q, write_d;
  logic                     cnt_load, cnt_dec, cnt_zero;

  wait_counter #(
    .Width(CountWidth)
  ) u_wait_counter (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .load_i    (cnt_load),
    .load_val_i(LoadVal),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Under contention the side that did not win last contention goes first.
  always_comb begin
    if (IReq && DReq) begin
      pick = (last_grant_q == GrantI) ? GrantD : GrantI;
    end else if (DReq) begin
      pick = GrantD;
    end else begin
      pick = GrantI;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    idata_d      = idata_q;
    drdata_d     = drdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      StIdle: begin
        if (IReq || DReq) begin
          grant_d = pick;
          if (IReq && DReq) begin
            last_grant_d = pick;
          end
          if (pick == GrantD) begin
            addr_d  = DAddr;
            wdata_d = DWData;
            write_d = DWrite;
          end else begin
            addr_d  = IAddr;
            write_d = 1'b0;
          end
          cnt_load = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_zero) begin
          if (!write_q) begin
            if (grant_q == GrantD) begin
              drdata_d = MemReadData;
            end else begin
              idata_d = MemReadData;
            end
          end
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      grant_q      <= GrantI;
      last_grant_q <= GrantI;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      idata_q      <= '0;
      drdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      idata_q      <= idata_d;
      drdata_q     <= drdata_d;
    end
  end

  // The write strobe is confined to the last access cycle so each store writes once.
  assign MemEnable    = (state_q == StAccess);
  assign MemWrite     = MemEnable && write_q && cnt_zero;
  assign IAck         = (state_q == StDone) && (grant_q == GrantI);
  assign DAck         = (state_q == StDone) && (grant_q == GrantD);
  assign Busy         = (state_q != StIdle);
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign IData        = idata_q;
  assign DRData       = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 2, 1, 3) share stimulus and are
// checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwrite;
  logic [31:0] iaddr, daddr, dwdata;
  logic [2:0]  iack, dack, men, mwr, busy;
  logic [31:0] idata[3], drdata[3], maddr[3], mwdata[3], mrdata[3];
  logic [31:0] emem[3][256];

  int checks = 0;
  int errors = 0;

  // Model state per instance: ph = cycles since grant, -1 when idle.
  int          ph[3];
  bit          win[3], lastg[3], mw[3];
  logic [31:0] ma[3], md[3], mi[3], mdr[3];
  logic [31:0] rmem[3][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (32),
      .MEM_LATENCY  ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .Clk         (clk),
      .Reset       (rst),
      .IReq        (ireq),
      .IAddr       (iaddr),
      .IAck        (iack[g]),
      .IData       (idata[g]),
      .DReq        (dreq),
      .DWrite      (dwrite),
      .DAddr       (daddr),
      .DWData      (dwdata),
      .DAck        (dack[g]),
      .DRData      (drdata[g]),
      .MemAddress  (maddr[g]),
      .MemWriteData(mwdata[g]),
      .MemEnable   (men[g]),
      .MemWrite    (mwr[g]),
      .MemReadData (mrdata[g]),
      .Busy        (busy[g])
    );
    assign mrdata[g] = emem[g][maddr[g][9:2]];
  end

  function automatic int lat(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      ph[g] = -1; win[g] = 1'b0; lastg[g] = 1'b0; mw[g] = 1'b0;
      ma[g] = '0; md[g] = '0; mi[g] = '0; mdr[g] = '0;
    end
  endtask

  // Advance the model across one rising edge using the inputs as sampled there.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int g = 0; g < 3; g++) begin
      if (ph[g] < 0) begin
        if (ireq || dreq) begin
          if (ireq && dreq) begin
            win[g]   = ~lastg[g];
            lastg[g] = win[g];
          end else begin
            win[g] = dreq;
          end
          ma[g] = win[g] ? daddr : iaddr;
          mw[g] = win[g] && dwrite;
          if (win[g]) md[g] = dwdata;
          ph[g] = 1;
        end
      end else if (ph[g] < lat(g)) begin
        ph[g]++;
      end else if (ph[g] == lat(g)) begin
        if (mw[g]) rmem[g][ma[g][9:2]] = md[g];
        else if (win[g]) mdr[g] = rmem[g][ma[g][9:2]];
        else mi[g] = rmem[g][ma[g][9:2]];
        ph[g]++;
      end else begin
        ph[g] = -1;
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 3; g++) begin
      bit acc, fin, wexp;
      acc  = (ph[g] >= 1) && (ph[g] <= lat(g));
      fin  = (ph[g] == lat(g) + 1);
      wexp = acc && (ph[g] == lat(g)) && mw[g];
      chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(ph[g] > 0));
      chk($sformatf("men%0d", g), 32'(men[g]), 32'(acc));
      chk($sformatf("mwr%0d", g), 32'(mwr[g]), 32'(wexp));
      chk($sformatf("iack%0d", g), 32'(iack[g]), 32'(fin && !win[g]));
      chk($sformatf("dack%0d", g), 32'(dack[g]), 32'(fin && win[g]));
      chk($sformatf("idata%0d", g), idata[g], mi[g]);
      chk($sformatf("drdata%0d", g), drdata[g], mdr[g]);
      if (acc) chk($sformatf("maddr%0d", g), maddr[g], ma[g]);
      if (wexp) chk($sformatf("mwdata%0d", g), mwdata[g], md[g]);
      if (mwr[g]) emem[g][maddr[g][9:2]] = mwdata[g];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Reset lands just after a rising edge, i.e. early in the following cycle.
  task automatic reset_pulse();
    @(posedge clk);
    model_step();
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    cyc();
    rst = 1'b0;
  endtask

  task automatic settle();
    ireq = 1'b0;
    dreq = 1'b0;
    repeat (6) cyc();
  endtask

  initial begin
    logic [31:0] v, w;
    rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwrite = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 256; i++) begin
        v = $urandom;
        emem[g][i] = v;
        rmem[g][i] = v;
      end
    end
    v = $urandom;
    w = $urandom;
    for (int g = 0; g < 3; g++) begin
      emem[g][4] = 32'h8C02_0004; rmem[g][4] = 32'h8C02_0004;
      emem[g][128] = v; rmem[g][128] = v;
      emem[g][192] = w; rmem[g][192] = w;
    end
    model_reset();
    repeat (2) cyc();
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_men", 32'(men[0]), 0);
    chk("rst_acks", 32'({iack[0], dack[0]}), 0);
    chk("rst_maddr", maddr[0], 0);
    chk("rst_mwdata", mwdata[0], 0);
    chk("rst_idata", idata[0], 0);
    rst = 1'b0;
    cyc();

    // Single fetch.
    ireq = 1'b1; iaddr = 32'h10;
    cyc(); chk("f_men_c1", 32'(men[0]), 1);
    cyc(); chk("f_men_c2", 32'(men[0]), 1);
    cyc(); chk("f_iack_c3", 32'(iack[0]), 1);
    chk("f_idata", idata[0], 32'h8C02_0004);
    ireq = 1'b0;
    cyc(); chk("f_busy_c4", 32'(busy[0]), 0);
    settle();

    // Single store.
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF;
    cyc(); chk("s_mwr_c1", 32'(mwr[0]), 0);
    cyc(); chk("s_mwr_c2", 32'(mwr[0]), 1);
    chk("s_maddr", maddr[0], 32'h100);
    chk("s_mwdata", mwdata[0], 32'hDEAD_BEEF);
    cyc(); chk("s_dack_c3", 32'(dack[0]), 1);
    chk("s_mwr_c3", 32'(mwr[0]), 0);
    dreq = 1'b0; dwrite = 1'b0;
    settle();
    chk("s_drdata", drdata[0], 0);

    // Contention from a fresh reset: D, I, D.
    reset_pulse();
    ireq = 1'b1; iaddr = 32'h20; dreq = 1'b1; dwrite = 1'b0; daddr = 32'h24;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      chk($sformatf("c_iack_c%0d", c), 32'(iack[0]), 32'(c == 7));
      chk($sformatf("c_dack_c%0d", c), 32'(dack[0]), 32'((c == 3) || (c == 11)));
    end
    settle();

    // Request dropped mid-access still completes.
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h200;
    cyc(); dreq = 1'b0;
    cyc();
    cyc(); chk("d_dack_c3", 32'(dack[0]), 1);
    chk("d_drdata", drdata[0], v);
    settle();

    // Reset early in a store leaves memory untouched.
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h300; dwdata = ~w;
    reset_pulse();
    dreq = 1'b0; dwrite = 1'b0;
    chk("r_busy0", 32'(busy[0]), 0);
    chk("r_busy2", 32'(busy[2]), 0);
    chk("r_dack2", 32'(dack[2]), 0);
    chk("r_mem2", emem[2][192], w);
    dreq = 1'b1;
    cyc(); cyc(); cyc();
    chk("r_dack_c3", 32'(dack[0]), 1);
    chk("r_drdata", drdata[0], w);
    settle();

    // Latency 1, back-to-back loads with operands churning after grant.
    dreq = 1'b1; dwrite = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      chk($sformatf("l1_dack_c%0d", c), 32'(dack[1]), 32'((c % 3) == 2));
      daddr = 32'($urandom_range(0, 255)) << 2;
    end
    settle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ireq = ~ireq;
      if ($urandom_range(0, 3) == 0) dreq = ~dreq;
      iaddr  = 32'($urandom_range(0, 255)) << 2;
      daddr  = 32'($urandom_range(0, 255)) << 2;
      dwdata = $urandom;
      dwrite = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else cyc();
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
